// File: rtl/apb_reg_slave.sv
// APB register responder: read-only ID at word 0, R/W words above it, programmable wait states.
// Define APB_SLV_PROTOCOL_CHECK_EN to build the sticky PROT_ERR protocol checker.
module apb_reg_slave #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [NUM_REGS*32-1:0] REG_OUT,
  output logic                   PROT_ERR
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic          valid_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [3:0]    cnt_q;
  logic [31:0]   prdata_q;
  logic          pready_q;
  logic          pslverr_q;
  logic [31:0]   regs_q [1:NUM_REGS-1];

  logic [9:0]    in_idx;
  logic          in_valid;
  logic          setup;
  logic          sel_valid;
  logic          sel_write;
  logic [IW-1:0] sel_idx;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic          unused_addr_hi;

  assign in_idx         = PADDR[11:2];
  assign in_valid       = (PADDR[1:0] == 2'b00) && (int'(in_idx) < NUM_REGS);
  assign setup          = PSEL && !PENABLE;
  assign unused_addr_hi = ^PADDR[31:12];

  // Zero-wait responses are built from the live bus; otherwise from the latched setup.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (that would infer a latch).
    sel_valid = valid_q;
    sel_write = write_q;
    sel_idx   = idx_q;
    if (state_q == S_IDLE) begin
      sel_valid = in_valid;
      sel_write = PWRITE;
      sel_idx   = in_idx[IW-1:0];
    end
    err_d   = !sel_valid || (sel_write && (sel_idx == '0));
    rdata_d = '0;
    if (!err_d && !sel_write) begin
      rdata_d = (sel_idx == '0) ? ID_VALUE : regs_q[sel_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      // NOTE: the register file is architecturally visible on REG_OUT, so it is reset like any other state.
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (setup) begin
            idx_q   <= in_idx[IW-1:0];
            valid_q <= in_valid;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt_q   <= '0;
            if (WAIT_STATES == 0) begin
              state_q   <= S_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rdata_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'(WAIT_STATES - 1)) begin
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err_d;
            prdata_q  <= rdata_d;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          // A dropped PSEL here is an abort: the write is discarded.
          if (PSEL && write_q && !pslverr_q) regs_q[idx_q] <= wdata_q;
          state_q   <= S_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

  assign REG_OUT[31:0] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg_out
    assign REG_OUT[32*g +: 32] = regs_q[g];
  end

`ifdef APB_SLV_PROTOCOL_CHECK_EN
  logic [31:0] addr_q;
  logic        prot_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q <= '0;
      prot_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && setup) addr_q <= PADDR;
      if ((state_q == S_IDLE) && PSEL && PENABLE) prot_q <= 1'b1;
      if ((state_q != S_IDLE) &&
          (!PSEL || (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q))) begin
        prot_q <= 1'b1;
      end
    end
  end

  assign PROT_ERR = prot_q;
`else
  assign PROT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: a zero-wait and a three-wait instance, table vectors plus scoreboard.
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_PROTOCOL_CHECK_EN
  localparam logic EXP_PROT = 1'b1;
`else
  localparam logic EXP_PROT = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          d3;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  logic         HCLK;
  logic         rst0, rst3;
  logic         psel0, pen0, pwr0, psel3, pen3, pwr3;
  logic [31:0]  paddr0, pwdata0, paddr3, pwdata3;
  logic [31:0]  prdata0, prdata3;
  logic         ready0, ready3, slverr0, slverr3, prot0, prot3;
  logic [255:0] regout0, regout3;

  int   n_checks;
  int   n_errors;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  logic [31:0] m0[8];
  logic [31:0] m3[8];
  vec_t vecs[16];

  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
    .HCLK(HCLK), .HRESET(rst0), .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0),
    .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PREADY(ready0),
    .PSLVERR(slverr0), .REG_OUT(regout0), .PROT_ERR(prot0)
  );

  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(ID)) u_dut3 (
    .HCLK(HCLK), .HRESET(rst3), .PSEL(psel3), .PENABLE(pen3), .PWRITE(pwr3),
    .PADDR(paddr3), .PWDATA(pwdata3), .PRDATA(prdata3), .PREADY(ready3),
    .PSLVERR(slverr3), .REG_OUT(regout3), .PROT_ERR(prot3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit d3, input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] w);
    if (d3) begin
      psel3 = sel; pen3 = en; pwr3 = wr; paddr3 = a; pwdata3 = w;
    end else begin
      psel0 = sel; pen0 = en; pwr0 = wr; paddr0 = a; pwdata0 = w;
    end
  endtask

  function automatic logic get_ready(input bit d3);
    return d3 ? ready3 : ready0;
  endfunction

  function automatic logic [31:0] word(input bit d3, input int i);
    return d3 ? regout3[32*i +: 32] : regout0[32*i +: 32];
  endfunction

  function automatic logic [255:0] model_vec(input bit d3);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = d3 ? m3[i] : m0[i];
    return v;
  endfunction

  // Scoreboard: every PREADY pulse must match the oldest pending expectation.
  always @(negedge HCLK) begin
    if (ready0 === 1'b1) begin
      if (q0.size() == 0) check("sb0_unexpected_pready", ready0, 1'b0);
      else begin
        e0 = q0.pop_front();
        check("sb0_prdata", prdata0, e0.rdata);
        check("sb0_pslverr", slverr0, e0.err);
      end
    end else if (ready0 === 1'b0) begin
      check("sb0_prdata_idle", prdata0, 32'h0);
    end
    if (ready3 === 1'b1) begin
      if (q3.size() == 0) check("sb3_unexpected_pready", ready3, 1'b0);
      else begin
        e3 = q3.pop_front();
        check("sb3_prdata", prdata3, e3.rdata);
        check("sb3_pslverr", slverr3, e3.err);
      end
    end else if (ready3 === 1'b0) begin
      check("sb3_prdata_idle", prdata3, 32'h0);
    end
  end

  // One full transfer; called at posedge+1 and returns at posedge+1 after the response.
  task automatic xfer(input bit d3, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd);
    int   lat;
    int   idx;
    exp_t e;
    idx     = int'(addr[11:2]);
    e.err   = exp_err;
    e.rdata = exp_rd;
    if (d3) q3.push_back(e); else q0.push_back(e);
    drive(d3, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge HCLK); #1;
    drive(d3, 1'b1, 1'b1, wr, addr, wdata);
    lat = 0;
    do begin
      @(negedge HCLK);
      lat++;
    end while (!get_ready(d3) && lat < 20);
    check($sformatf("latency_dut%0d_%0h", d3 ? 3 : 0, addr), lat, d3 ? 4 : 1);
    if (wr && !exp_err) check("reg_before_commit", word(d3, idx), d3 ? m3[idx] : m0[idx]);
    @(posedge HCLK); #1;
    drive(d3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    if (wr && !exp_err) begin
      if (d3) m3[idx] = wdata; else m0[idx] = wdata;
      check("reg_after_commit", word(d3, idx), wdata);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0[i] = '0;
      m3[i] = '0;
    end
    m0[0] = ID;
    m3[0] = ID;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, ID};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_001C, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_001C, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b0, 32'h1000_0004, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, ID};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0009, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_001C, 32'h0,         1'b0, 32'h0};

    repeat (2) @(posedge HCLK);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge HCLK);
    check("rst_pready0", ready0, 1'b0);
    check("rst_pslverr0", slverr0, 1'b0);
    check("rst_prot0", prot0, 1'b0);
    check("rst_regout0", regout0, model_vec(1'b0));
    check("rst_pready3", ready3, 1'b0);
    check("rst_pslverr3", slverr3, 1'b0);
    check("rst_prot3", prot3, 1'b0);
    check("rst_regout3", regout3, model_vec(1'b1));
    @(posedge HCLK); #1;

    // Table vectors, issued back-to-back.
    foreach (vecs[i]) xfer(vecs[i].d3, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rd);
    check("regout0_after_table", regout0, model_vec(1'b0));
    check("regout3_after_table", regout3, model_vec(1'b1));
    check("prot0_legal_traffic", prot0, 1'b0);
    check("prot3_legal_traffic", prot3, 1'b0);

    // PSEL low in IDLE: bus noise must be ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("idle_noise_pready0", ready0, 1'b0);
    end
    @(posedge HCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("idle_noise_reg1", word(1'b0, 1), 32'hDEAD_BEEF);
    check("idle_noise_prot0", prot0, 1'b0);

    // Access phase without setup.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    @(posedge HCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge HCLK);
    check("no_setup_pready0", ready0, 1'b0);
    check("no_setup_prot0", prot0, EXP_PROT);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("no_setup_prot0_sticky", prot0, EXP_PROT);
    @(posedge HCLK); #1;

    // Abort in RESP on the zero-wait instance: response is seen, write is dropped.
    e0.err = 1'b0;
    e0.rdata = 32'h0;
    q0.push_back(e0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0018, 32'h6666_6666);
    @(posedge HCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge HCLK); #1;
    check("abort_resp_reg6", word(1'b0, 6), 32'h0);
    check("abort_resp_pready0", ready0, 1'b0);

    // Reset of the zero-wait instance clears registers and PROT_ERR.
    rst0 = 1'b1;
    @(posedge HCLK); #1;
    rst0 = 1'b0;
    for (int i = 1; i < 8; i++) m0[i] = '0;
    @(negedge HCLK);
    check("rst2_prot0", prot0, 1'b0);
    check("rst2_regout0", regout0, model_vec(1'b0));
    @(posedge HCLK); #1;

    // HRESET during WAIT of a write to word 3.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h55AA_55AA);
    @(posedge HCLK); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h55AA_55AA);
    @(posedge HCLK); #1;
    rst3 = 1'b1;
    @(posedge HCLK); #1;
    rst3 = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 8; i++) m3[i] = '0;
    @(negedge HCLK);
    check("midrst_pready3", ready3, 1'b0);
    check("midrst_pslverr3", slverr3, 1'b0);
    check("midrst_prot3", prot3, 1'b0);
    check("midrst_regout3", regout3, model_vec(1'b1));
    repeat (5) @(posedge HCLK);
    #1;
    check("midrst_reg3_later", word(1'b1, 3), 32'h0);
    xfer(1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h0);

    // PSEL dropped during WAIT: no response, no write.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0014, 32'h7777_7777);
    @(posedge HCLK); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0014, 32'h7777_7777);
    @(posedge HCLK); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    check("abort_wait_reg5", word(1'b1, 5), 32'h0);
    check("abort_wait_pready3", ready3, 1'b0);
    check("abort_wait_prot3", prot3, EXP_PROT);
    @(posedge HCLK); #1;
    xfer(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0);
    xfer(1'b1, 1'b1, 32'h0000_0014, 32'h7777_7777, 1'b0, 32'h0);
    xfer(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h7777_7777);
    check("final_regout3", regout3, model_vec(1'b1));

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("sb0_drained", q0.size(), 0);
    check("sb3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
